// File: rtl/ysyx_22050598_sirv_gnrl_pipe_chain.sv
// ysyx_22050598_sirv_gnrl_pipe_chain
//   Elastic pipeline of DEPTH register stages with valid/ready handshakes on both ends.
//   Beats move only on handshake, so order is kept and no beat is lost or duplicated.
//   It also has a synchronous flush and a registered occupancy count.
//
// Parameters
//   DW        data width
//   DEPTH     number of stages
//   RESET_VAL reset value of every stage data register
//
// Ports
//   clk    clock, posedge
//   rst_n  synchronous active-low reset
//   flush  drops every buffered beat; no transfers in that cycle
//   i_vld / i_rdy / i_dat   upstream handshake and data
//   o_vld / o_rdy / o_dat   downstream handshake and data (o_dat is the last stage register)
//   o_cnt  number of beats currently held
//
// Build option
//   YSYX_22050598_PIPE_CHAIN_SKID_EN: each stage gets a main and a skid register. Every ready,
//   including i_rdy, then comes straight from a register, and each stage holds up to two beats.
//   When the option is not set, each stage has one register and the ready chain is combinational.
module ysyx_22050598_sirv_gnrl_pipe_chain #(
   parameter int unsigned     DW        = 64,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [DW-1:0]   RESET_VAL = '0,
   localparam int unsigned    CW        = $clog2(2 * DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [CW-1:0] o_cnt
);

   logic          stage_rdy0;
   logic          last_vld;
   logic [DW-1:0] last_dat;
   logic          in_fire;
   logic          out_fire;
   logic [CW-1:0] cnt_q;

   // Reset and flush block both ends combinationally, so no handshake completes in those cycles.
   assign i_rdy    = rst_n & ~flush & stage_rdy0;
   assign o_vld    = rst_n & ~flush & last_vld;
   assign o_dat    = last_dat;
   assign o_cnt    = cnt_q;
   assign in_fire  = i_vld & i_rdy;
   assign out_fire = o_vld & o_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(in_fire) - CW'(out_fire);
      end
   end

`ifdef YSYX_22050598_PIPE_CHAIN_SKID_EN

   logic [DEPTH-1:0] m_vld_q;
   logic [DEPTH-1:0] s_vld_q;
   logic [DW-1:0]    m_dat_q [DEPTH];
   logic [DW-1:0]    s_dat_q [DEPTH];
   logic [DEPTH-1:0] src_vld;
   logic [DW-1:0]    src_dat [DEPTH];
   logic [DEPTH-1:0] dn_rdy;

   for (genvar g = 0; g < DEPTH; g++) begin : g_link
      if (g == 0) begin : g_head
         assign src_vld[g] = i_vld;
         assign src_dat[g] = i_dat;
      end else begin : g_body
         assign src_vld[g] = m_vld_q[g-1];
         assign src_dat[g] = m_dat_q[g-1];
      end
      // Downstream readiness is the next stage's registered "skid empty" flag.
      if (g == DEPTH - 1) begin : g_tail
         assign dn_rdy[g] = o_rdy;
      end else begin : g_mid
         assign dn_rdy[g] = ~s_vld_q[g+1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_vld_q <= '0;
         s_vld_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            m_dat_q[k] <= RESET_VAL;
            s_dat_q[k] <= RESET_VAL;
         end
      end else if (flush) begin
         m_vld_q <= '0;
         s_vld_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (~m_vld_q[k] | dn_rdy[k]) begin
               // Main frees up: a parked skid beat goes first so that order is kept.
               if (s_vld_q[k]) begin
                  m_vld_q[k] <= 1'b1;
                  m_dat_q[k] <= s_dat_q[k];
                  s_vld_q[k] <= 1'b0;
               end else begin
                  m_vld_q[k] <= src_vld[k];
                  if (src_vld[k]) m_dat_q[k] <= src_dat[k];
               end
            end else if (src_vld[k] & ~s_vld_q[k]) begin
               // Main stalled, but this stage still advertised ready: park the beat.
               s_vld_q[k] <= 1'b1;
               s_dat_q[k] <= src_dat[k];
            end
         end
      end
   end

   assign stage_rdy0 = ~s_vld_q[0];
   assign last_vld   = m_vld_q[DEPTH-1];
   assign last_dat   = m_dat_q[DEPTH-1];

`else

   logic [DEPTH-1:0] vld_q;
   logic [DW-1:0]    dat_q [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_vld;
   logic [DW-1:0]    src_dat [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_link
      if (g == 0) begin : g_head
         assign src_vld[g] = i_vld;
         assign src_dat[g] = i_dat;
      end else begin : g_body
         assign src_vld[g] = vld_q[g-1];
         assign src_dat[g] = dat_q[g-1];
      end
   end

   // A stage can load when it is empty or when the stage after it can load too.
   // The chain is built from a running term, so no vector bit depends on another bit of itself.
   always_comb begin : ready_chain
      logic r;
      r = o_rdy;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         r = ~vld_q[k] | r;
         rdy[k] = r;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dat_q[k] <= RESET_VAL;
         end
      end else if (flush) begin
         vld_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
               vld_q[k] <= src_vld[k];
               // Data loads only when a real beat enters, so bubbles leave it unchanged.
               if (src_vld[k]) dat_q[k] <= src_dat[k];
            end
         end
      end
   end

   assign stage_rdy0 = rdy[0];
   assign last_vld   = vld_q[DEPTH-1];
   assign last_dat   = dat_q[DEPTH-1];

`endif

endmodule

// File: tb/tb_ysyx_22050598_sirv_gnrl_pipe_chain.sv
// Testbench for ysyx_22050598_sirv_gnrl_pipe_chain (DW=8, DEPTH=3, RESET_VAL=8'hA5).
// Reference model: a FIFO of accepted beats, each tagged with its accept cycle. A beat shows at
// the output DEPTH cycles after it is accepted, and never before the cycle after the previous
// beat left. The block refuses input only when it holds DEPTH beats and o_rdy is low.
module tb_ysyx_22050598_sirv_gnrl_pipe_chain;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 3;
   localparam logic [7:0]  RVAL  = 8'hA5;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       i_vld;
   logic       i_rdy;
   logic [7:0] i_dat;
   logic       o_vld;
   logic       o_rdy;
   logic [7:0] o_dat;
   logic [2:0] o_cnt;

   ysyx_22050598_sirv_gnrl_pipe_chain #(
      .DW        (DW),
      .DEPTH     (DEPTH),
      .RESET_VAL (RVAL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat),
      .o_cnt (o_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] dat;
      int         acc;
   } beat_t;

   beat_t      q[$];
   int         cyc;
   int         last_pop;
   logic [7:0] last_vis;
   int         n_chk;
   int         n_pass;
   logic       exp_irdy_last;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Drive one cycle of inputs, check outputs against the model, then advance the model.
   task automatic step(input logic rn, input logic fl, input logic iv, input logic [7:0] id,
                       input logic ordy);
      logic       vis;
      logic       exp_ovld;
      logic       exp_irdy;
      logic [7:0] exp_dat;
      beat_t      b;
      rst_n = rn;
      flush = fl;
      i_vld = iv;
      i_dat = id;
      o_rdy = ordy;
      #1;
      vis = (q.size() > 0) && (cyc >= q[0].acc + int'(DEPTH)) && (cyc > last_pop);
      exp_dat = vis ? q[0].dat : last_vis;
      if (vis) last_vis = q[0].dat;
      exp_ovld = vis & rn & ~fl;
      exp_irdy = rn & ~fl & ((q.size() < int'(DEPTH)) | ordy);
      exp_irdy_last = exp_irdy;
      chk("i_rdy", 32'(i_rdy), 32'(exp_irdy));
      chk("o_vld", 32'(o_vld), 32'(exp_ovld));
      chk("o_cnt", 32'(o_cnt), 32'(q.size()));
      chk("o_dat", 32'(o_dat), 32'(exp_dat));
      @(posedge clk);
      if (!rn) begin
         q.delete();
         last_vis = RVAL;
      end else if (fl) begin
         q.delete();
      end else begin
         if (exp_ovld & ordy) begin
            void'(q.pop_front());
            last_pop = cyc;
         end
         if (iv & exp_irdy) begin
            b.dat = id;
            b.acc = cyc;
            q.push_back(b);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int   guard;
      logic [7:0] v;
      n_chk    = 0;
      n_pass   = 0;
      cyc      = 0;
      last_pop = -1000;
      last_vis = RVAL;
      rst_n    = 1'b0;
      flush    = 1'b0;
      i_vld    = 1'b0;
      i_dat    = 8'h00;
      o_rdy    = 1'b0;
      // The first reset edge brings the registers to known values; checking starts after it.
      @(posedge clk);
      cyc = 1;
      @(negedge clk);

      // 1: reset held, then released
      step(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // 2: streaming 1..10 with o_rdy high, then let it drain
      for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b1);

      // 3: stall output and fill until input is refused, then drain
      v = 8'd11;
      guard = 0;
      exp_irdy_last = 1'b1;
      while (exp_irdy_last && guard < 10) begin
         step(1'b1, 1'b0, 1'b1, v, 1'b0);
         v++;
         guard++;
      end
      step(1'b1, 1'b0, 1'b1, v, 1'b0);
      chk("fill_cnt", 32'(o_cnt), 32'(DEPTH));
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // 4: full chain streaming with both ends active
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h50 + i), 1'b1);

      // 5: flush a full chain
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("flush_cnt", 32'(o_cnt), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h70 + i), 1'b1);

      // 6: mid-stream reset pulse, then normal traffic
      step(1'b1, 1'b0, 1'b1, 8'h81, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h82, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'h83, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst_odat", 32'(o_dat), 32'(RVAL));
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h90 + i), 1'b1);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 97) != 0, ($urandom % 41) == 0, ($urandom % 4) != 0,
              8'($urandom), ($urandom % 3) != 0);
      end
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
